// File: rtl/mpsoc_dbg_jsp_wb_pump_if.sv
// Wishbone bundle between the JSP pump (master) and the JSP register window (slave).
// 8-bit data and a 3-bit register address.
interface mpsoc_dbg_jsp_wb_pump_if;
  logic       wbm_cyc_o;
  logic       wbm_stb_o;
  logic       wbm_we_o;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_ack_i;
  logic       wbm_err_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/mpsoc_dbg_jsp_wb_pump.sv
// Wishbone master that polls the JSP line status register, drains received bytes into
// a one-byte rx stream buffer and writes bytes from a tx stream into the THR.
module mpsoc_dbg_jsp_wb_pump #(
  parameter int POLL_INTERVAL = 16,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  mpsoc_dbg_jsp_wb_pump_if.master       wbm,
  input  logic                          int_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          err_o,
  input  logic                          err_clr_i
);

  localparam int PW = $clog2(POLL_INTERVAL + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(ACK_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POLL   = 3'd1;
  localparam logic [2:0] S_DECIDE = 3'd2;
  localparam logic [2:0] S_RD_RBR = 3'd3;
  localparam logic [2:0] S_WR_THR = 3'd4;

  localparam logic [2:0] ADR_RBR = 3'd0;
  localparam logic [2:0] ADR_LSR = 3'd5;

  logic [2:0]    state;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          lsr_dr;
  logic          lsr_thre;

  // Bus states start their cycle while cyc is low; a finished cycle always leaves the
  // state, so cyc low in a bus state means "not started yet" and the gap cycle is implicit.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= S_IDLE;
      poll_cnt      <= POLL_RELOAD;
      tmo_cnt       <= '0;
      lsr_dr        <= 1'b0;
      lsr_thre      <= 1'b0;
      wbm.wbm_cyc_o <= 1'b0;
      wbm.wbm_stb_o <= 1'b0;
      wbm.wbm_we_o  <= 1'b0;
      wbm.wbm_adr_o <= 3'd0;
      wbm.wbm_dat_o <= 8'h00;
      rx_data_o     <= 8'h00;
      rx_valid_o    <= 1'b0;
      tx_ready_o    <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      tx_ready_o <= 1'b0;
      if (err_clr_i)
        err_o <= 1'b0;
      if (rx_valid_o && rx_ready_i)
        rx_valid_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (int_i || tx_valid_i || poll_cnt == '0)
            state <= S_POLL;
          else
            poll_cnt <= poll_cnt - 1'b1;
        end

        S_DECIDE: begin
          if (lsr_dr && !rx_valid_o)
            state <= S_RD_RBR;
          else if (lsr_thre && tx_valid_i)
            state <= S_WR_THR;
          else begin
            poll_cnt <= POLL_RELOAD;
            state    <= S_IDLE;
          end
        end

        S_POLL, S_RD_RBR, S_WR_THR: begin
          if (!wbm.wbm_cyc_o) begin
            wbm.wbm_cyc_o <= 1'b1;
            wbm.wbm_stb_o <= 1'b1;
            wbm.wbm_we_o  <= (state == S_WR_THR);
            wbm.wbm_adr_o <= (state == S_POLL) ? ADR_LSR : ADR_RBR;
            wbm.wbm_dat_o <= (state == S_WR_THR) ? tx_data_i : 8'h00;
            tmo_cnt       <= '0;
          end else if (wbm.wbm_err_i || (!wbm.wbm_ack_i && tmo_cnt == TMO_LAST)) begin
            // Error outranks a simultaneous ack: nothing is loaded or consumed.
            wbm.wbm_cyc_o <= 1'b0;
            wbm.wbm_stb_o <= 1'b0;
            wbm.wbm_we_o  <= 1'b0;
            err_o         <= 1'b1;
            poll_cnt      <= POLL_RELOAD;
            state         <= S_IDLE;
          end else if (wbm.wbm_ack_i) begin
            wbm.wbm_cyc_o <= 1'b0;
            wbm.wbm_stb_o <= 1'b0;
            wbm.wbm_we_o  <= 1'b0;
            if (state == S_POLL) begin
              lsr_dr   <= wbm.wbm_dat_i[0];
              lsr_thre <= wbm.wbm_dat_i[5];
              state    <= S_DECIDE;
            end else if (state == S_RD_RBR) begin
              rx_data_o  <= wbm.wbm_dat_i;
              rx_valid_o <= 1'b1;
              state      <= S_POLL;
            end else begin
              tx_ready_o <= 1'b1;
              state      <= S_POLL;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_dbg_jsp_wb_pump.sv
// Directed bench for the JSP Wishbone pump: a scripted slave answers LSR/RBR reads and
// THR writes, and every expected value below is hand-derived cycle by cycle.
module tb_mpsoc_dbg_jsp_wb_pump;

  logic       wb_clk_i;
  logic       wb_rst_i;
  logic       int_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic       err_o;
  logic       err_clr_i;

  logic       ack_en;
  logic       err_en;
  logic [7:0] lsr_val;
  logic [7:0] rbr_val;

  int compared;
  int mismatched;
  int lsr_reads;
  int rbr_reads;
  int thr_writes;
  int tx_ready_pulses;
  int last_wdata;
  int bus_log[$];

  mpsoc_dbg_jsp_wb_pump_if wbm_if ();

  mpsoc_dbg_jsp_wb_pump #(
    .POLL_INTERVAL (4),
    .ACK_TIMEOUT   (8)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wbm        (wbm_if.master),
    .int_i      (int_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .err_o      (err_o),
    .err_clr_i  (err_clr_i)
  );

  // Scripted slave: zero-wait ack, LSR at address 5, RBR everywhere else.
  assign wbm_if.wbm_ack_i = wbm_if.wbm_cyc_o & wbm_if.wbm_stb_o & ack_en;
  assign wbm_if.wbm_err_i = wbm_if.wbm_cyc_o & wbm_if.wbm_stb_o & err_en;
  assign wbm_if.wbm_dat_i = (wbm_if.wbm_adr_o == 3'd5) ? lsr_val : rbr_val;

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Transaction log of completed (acked, non-error) bus cycles: we*16 + address.
  always @(posedge wb_clk_i) begin
    if (!wb_rst_i && wbm_if.wbm_cyc_o && wbm_if.wbm_stb_o && wbm_if.wbm_ack_i && !wbm_if.wbm_err_i) begin
      bus_log.push_back((wbm_if.wbm_we_o ? 16 : 0) + int'(wbm_if.wbm_adr_o));
      if (wbm_if.wbm_we_o) begin
        thr_writes++;
        last_wdata = int'(wbm_if.wbm_dat_o);
      end else if (wbm_if.wbm_adr_o == 3'd5)
        lsr_reads++;
      else
        rbr_reads++;
    end
    if (!wb_rst_i && tx_ready_o)
      tx_ready_pulses++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic applyStimulus(input logic int_v, input logic txv, input logic [7:0] txd, input logic rxr);
    int_i      = int_v;
    tx_valid_i = txv;
    tx_data_i  = txd;
    rx_ready_i = rxr;
  endtask

  task automatic applyReset();
    wb_rst_i  = 1'b1;
    err_clr_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    waitCycles(2);
    wb_rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lsr_base, rbr_base, thr_base, pulse_base, log_base, seen;
    compared = 0; mismatched = 0;
    lsr_reads = 0; rbr_reads = 0; thr_writes = 0; tx_ready_pulses = 0; last_wdata = 0;
    ack_en = 1'b1; err_en = 1'b0; lsr_val = 8'h00; rbr_val = 8'h00;
    wb_rst_i = 1'b1; err_clr_i = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
    @(negedge wb_clk_i);

    // Reset state, with requests pending that must be ignored.
    waitCycles(2);
    checkOutput("rst_cyc", wbm_if.wbm_cyc_o, 0);
    checkOutput("rst_stb", wbm_if.wbm_stb_o, 0);
    checkOutput("rst_we", wbm_if.wbm_we_o, 0);
    checkOutput("rst_adr", wbm_if.wbm_adr_o, 0);
    checkOutput("rst_dat", wbm_if.wbm_dat_o, 0);
    checkOutput("rst_rx_valid", rx_valid_o, 0);
    checkOutput("rst_rx_data", rx_data_o, 0);
    checkOutput("rst_tx_ready", tx_ready_o, 0);
    checkOutput("rst_err", err_o, 0);

    // Single rx byte: int_i -> rx_valid in 6 cycles, then the next LSR poll.
    applyReset();
    lsr_val = 8'h01; rbr_val = 8'h5A;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    waitCycles(1);
    checkOutput("rx1_e1_cyc", wbm_if.wbm_cyc_o, 0);
    waitCycles(1);
    checkOutput("rx1_e2_cyc", wbm_if.wbm_cyc_o, 1);
    checkOutput("rx1_e2_stb", wbm_if.wbm_stb_o, 1);
    checkOutput("rx1_e2_adr", wbm_if.wbm_adr_o, 5);
    checkOutput("rx1_e2_we", wbm_if.wbm_we_o, 0);
    waitCycles(1);
    checkOutput("rx1_e3_cyc", wbm_if.wbm_cyc_o, 0);
    waitCycles(2);
    checkOutput("rx1_e5_cyc", wbm_if.wbm_cyc_o, 1);
    checkOutput("rx1_e5_adr", wbm_if.wbm_adr_o, 0);
    checkOutput("rx1_e5_valid", rx_valid_o, 0);
    waitCycles(1);
    checkOutput("rx1_e6_valid", rx_valid_o, 1);
    checkOutput("rx1_e6_data", rx_data_o, 'h5A);
    lsr_val = 8'h00;
    int_i   = 1'b0;
    waitCycles(1);
    checkOutput("rx1_e7_valid", rx_valid_o, 0);
    checkOutput("rx1_e7_cyc", wbm_if.wbm_cyc_o, 1);
    checkOutput("rx1_e7_adr", wbm_if.wbm_adr_o, 5);

    // Rx backpressure: one RBR read, then only LSR polling until the byte is taken.
    applyReset();
    lsr_val = 8'h01; rbr_val = 8'h11;
    lsr_base = lsr_reads; rbr_base = rbr_reads;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    waitCycles(20);
    checkOutput("bp_mid_data", rx_data_o, 'h11);
    waitCycles(20);
    checkOutput("bp_rbr_reads", rbr_reads - rbr_base, 1);
    checkOutput("bp_lsr_polls", int'((lsr_reads - lsr_base) >= 3), 1);
    checkOutput("bp_valid", rx_valid_o, 1);
    checkOutput("bp_data", rx_data_o, 'h11);
    rbr_val    = 8'h22;
    rx_ready_i = 1'b1;
    waitCycles(1);
    rx_ready_i = 1'b0;
    checkOutput("bp_drop", rx_valid_o, 0);
    waitCycles(20);
    checkOutput("bp_rbr_reads2", rbr_reads - rbr_base, 2);
    checkOutput("bp_valid2", rx_valid_o, 1);
    checkOutput("bp_data2", rx_data_o, 'h22);
    // Reset with a byte held discards it.
    wb_rst_i = 1'b1;
    waitCycles(1);
    checkOutput("bp_rst_valid", rx_valid_o, 0);
    checkOutput("bp_rst_data", rx_data_o, 0);

    // Tx write: THRE set, one byte, ready pulse 6 cycles after tx_valid.
    applyReset();
    lsr_val = 8'h20;
    thr_base = thr_writes; pulse_base = tx_ready_pulses;
    applyStimulus(1'b0, 1'b1, 8'hA3, 1'b0);
    waitCycles(5);
    checkOutput("tx_e5_cyc", wbm_if.wbm_cyc_o, 1);
    checkOutput("tx_e5_we", wbm_if.wbm_we_o, 1);
    checkOutput("tx_e5_adr", wbm_if.wbm_adr_o, 0);
    checkOutput("tx_e5_dat", wbm_if.wbm_dat_o, 'hA3);
    checkOutput("tx_e5_ready", tx_ready_o, 0);
    waitCycles(1);
    checkOutput("tx_e6_ready", tx_ready_o, 1);
    tx_valid_i = 1'b0;
    waitCycles(1);
    checkOutput("tx_e7_ready", tx_ready_o, 0);
    waitCycles(20);
    checkOutput("tx_writes", thr_writes - thr_base, 1);
    checkOutput("tx_wdata", last_wdata, 'hA3);
    checkOutput("tx_pulses", tx_ready_pulses - pulse_base, 1);

    // Priority: DR and THRE both set -> RBR read, LSR re-poll, THR write.
    applyReset();
    lsr_val = 8'h21; rbr_val = 8'h77;
    log_base = bus_log.size();
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0);
    seen = 0;
    for (int i = 1; i <= 50; i++) begin
      waitCycles(1);
      if (tx_ready_o) begin
        seen = i;
        break;
      end
    end
    tx_valid_i = 1'b0;
    checkOutput("prio_tx_latency", seen, 11);
    checkOutput("prio_log0", (bus_log.size() > log_base + 0) ? bus_log[log_base + 0] : -1, 'h05);
    checkOutput("prio_log1", (bus_log.size() > log_base + 1) ? bus_log[log_base + 1] : -1, 'h00);
    checkOutput("prio_log2", (bus_log.size() > log_base + 2) ? bus_log[log_base + 2] : -1, 'h05);
    checkOutput("prio_log3", (bus_log.size() > log_base + 3) ? bus_log[log_base + 3] : -1, 'h10);
    checkOutput("prio_rx_data", rx_data_o, 'h77);
    checkOutput("prio_wdata", last_wdata, 'h3C);

    // Timeout: slave never acks, cyc held 8 cycles, sticky err until cleared.
    applyReset();
    lsr_val = 8'h00; ack_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    waitCycles(1);
    int_i = 1'b0;
    waitCycles(1);
    checkOutput("tmo_e2_cyc", wbm_if.wbm_cyc_o, 1);
    waitCycles(7);
    checkOutput("tmo_e9_cyc", wbm_if.wbm_cyc_o, 1);
    checkOutput("tmo_e9_err", err_o, 0);
    waitCycles(1);
    checkOutput("tmo_e10_cyc", wbm_if.wbm_cyc_o, 0);
    checkOutput("tmo_e10_err", err_o, 1);
    ack_en = 1'b1;
    waitCycles(10);
    checkOutput("tmo_sticky", err_o, 1);
    err_clr_i = 1'b1;
    waitCycles(1);
    err_clr_i = 1'b0;
    checkOutput("tmo_cleared", err_o, 0);

    // Bus error together with ack and err_clr: error wins on both counts.
    applyReset();
    lsr_val = 8'h01; ack_en = 1'b1; err_en = 1'b1;
    err_clr_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    waitCycles(1);
    int_i = 1'b0;
    waitCycles(1);
    checkOutput("berr_e2_cyc", wbm_if.wbm_cyc_o, 1);
    checkOutput("berr_e2_err", err_o, 0);
    waitCycles(1);
    checkOutput("berr_e3_cyc", wbm_if.wbm_cyc_o, 0);
    checkOutput("berr_e3_err", err_o, 1);
    waitCycles(1);
    checkOutput("berr_e4_err", err_o, 0);
    checkOutput("berr_e4_cyc", wbm_if.wbm_cyc_o, 0);
    checkOutput("berr_rx_valid", rx_valid_o, 0);
    err_clr_i = 1'b0; err_en = 1'b0; lsr_val = 8'h00;

    // Reset mid RBR read (slave stalled), then first poll POLL_INTERVAL cycles later.
    applyReset();
    lsr_val = 8'h01; rbr_val = 8'h99;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    waitCycles(1);
    int_i = 1'b0;
    waitCycles(3);
    ack_en = 1'b0;
    waitCycles(1);
    checkOutput("mid_rbr_cyc", wbm_if.wbm_cyc_o, 1);
    checkOutput("mid_rbr_adr", wbm_if.wbm_adr_o, 0);
    wb_rst_i = 1'b1;
    waitCycles(1);
    checkOutput("mid_rst_cyc", wbm_if.wbm_cyc_o, 0);
    checkOutput("mid_rst_stb", wbm_if.wbm_stb_o, 0);
    checkOutput("mid_rst_adr", wbm_if.wbm_adr_o, 0);
    checkOutput("mid_rst_valid", rx_valid_o, 0);
    ack_en = 1'b1; lsr_val = 8'h00;
    wb_rst_i = 1'b0;
    waitCycles(4);
    checkOutput("mid_poll_e4_cyc", wbm_if.wbm_cyc_o, 0);
    waitCycles(1);
    checkOutput("mid_poll_e5_cyc", wbm_if.wbm_cyc_o, 1);
    checkOutput("mid_poll_e5_adr", wbm_if.wbm_adr_o, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mpsoc_dbg_jsp_wb_pump.md
# mpsoc_dbg_jsp_wb_pump

Single-clock Wishbone master that services the Wishbone slave side of the JTAG Serial Port (the 16550-style register window with `int_o`) on behalf of on-chip logic. It polls the line status register, drains received bytes into a valid/ready byte stream, and writes bytes from a second stream into the transmit holding register. It sits directly downstream of the JSP Wishbone slave, in the `wb_clk_i` domain.

## Interface
Parameters:
- `POLL_INTERVAL`, 16: idle cycles between LSR polls when `int_i` is low; must be ≥1.
- `ACK_TIMEOUT`, 255: cycles a bus cycle may wait for ack/err before it is aborted; must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: synchronous active-high reset.
- `wbm_cyc_o` in/out: `wbm_cyc_o` out 1: Wishbone cycle.
- `wbm_stb_o` out 1: Wishbone strobe.
- `wbm_we_o` out 1: write enable.
- `wbm_adr_o` out 3: register address.
- `wbm_dat_o` out 8: write data.
- `wbm_dat_i` in 8: read data.
- `wbm_ack_i` in 1: acknowledge.
- `wbm_err_i` in 1: bus error.
- `int_i` in 1: JSP interrupt; a high level forces an immediate poll.
- `rx_data_o` out 8: received byte.
- `rx_valid_o` out 1: `rx_data_o` is valid.
- `rx_ready_i` in 1: consumer accepts the byte.
- `tx_data_i` in 8: byte to transmit.
- `tx_valid_i` in 1: `tx_data_i` is valid.
- `tx_ready_o` out 1: one-cycle pulse; the byte has been written.
- `err_o` out 1: sticky flag for bus error or timeout.
- `err_clr_i` in 1: clears `err_o`.

## Operation
- Register map: address 0 is RBR (read) / THR (write). Address 5 is LSR, where bit 0 = DR (data ready) and bit 5 = THRE (THR empty).
- FSM states: IDLE, POLL, DECIDE, RD_RBR, WR_THR.
- **IDLE:** the poll counter counts down from `POLL_INTERVAL`-1. Go to POLL when the counter reaches 0, or at once when `int_i`=1 or `tx_valid_i`=1.
- **POLL:** read address 5 and latch LSR on ack. Go to DECIDE.
- **DECIDE** (one cycle), in priority order:
  - DR=1 and the rx buffer is empty: go to RD_RBR.
  - Otherwise THRE=1 and `tx_valid_i`=1: go to WR_THR.
  - Otherwise reload the poll counter and go to IDLE.
- **RD_RBR:** read address 0. On ack, load `rx_data_o` and set `rx_valid_o`. Go to POLL.
- **WR_THR:** write `tx_data_i` to address 0. On ack, pulse `tx_ready_o` for one cycle. Go to POLL.
- Rx buffer holds one byte:
  - `rx_valid_o` stays high with `rx_data_o` stable until a cycle with `rx_ready_i`=1.
  - RBR is never read while the buffer is full.
- A tx byte is consumed only on ack. `tx_data_i` must stay stable while `tx_valid_i`=1 and `tx_ready_o` has not pulsed.
- Bus cycle rules:
  - `wbm_cyc_o` and `wbm_stb_o` rise together and are held, with address, data and `we` stable.
  - They drop in the cycle after ack, err or timeout.
  - There is at least one idle cycle between consecutive bus cycles.
- Error handling:
  - `wbm_err_i`, or `ACK_TIMEOUT` cycles without ack/err, ends the cycle and sets `err_o`.
  - The FSM returns to IDLE with no rx load and no `tx_ready_o` pulse.
  - If ack and err arrive in the same cycle, err wins.
  - If `err_clr_i` and a new error arrive in the same cycle, `err_o` stays 1.

## Timing
- Reset values: all outputs 0, `wbm_adr_o`=0, FSM in IDLE, poll counter = `POLL_INTERVAL`-1, LSR latch = 0.
- Reset mid bus cycle: `wbm_cyc_o`/`wbm_stb_o` drop in the next cycle; a held rx byte is discarded.
- Bus-cycle latency: `wbm_cyc_o` rises in the cycle after the state is entered. With a slave that acks in the same cycle as `stb`, an LSR read is 2 cycles (assert, then drop).
- Best case from `int_i` rising to `rx_valid_o` high: 1 (IDLE→POLL) + 2 (LSR) + 1 (DECIDE) + 2 (RBR) = 6 cycles.
- Rx drop and refill:
  - `rx_valid_o` drops in the cycle after the handshake.
  - A handshake in the same cycle as an RBR ack cannot occur, because RBR is only read when the buffer is empty.
- Tx latency: best case from `tx_valid_i` rising in IDLE to `tx_ready_o` = 6 cycles.
- Poll counter: it wraps by reloading, never underflows. The timeout counter clears at the start of each bus cycle.

## Test plan
- **Single rx byte.** Slave returns LSR=0x01, then RBR=0x5A, with `rx_ready_i`=1 → `rx_valid_o` pulses with `rx_data_o`=0x5A, and the next LSR poll follows.
- **Rx backpressure.** Hold `rx_ready_i`=0 with LSR DR=1 permanently → exactly one RBR read; `rx_data_o` stays stable; only LSR reads continue. After `rx_ready_i`=1 is asserted, the second byte is read.
- **Tx write.** Drive `tx_valid_i`=1 with 0xA3 and LSR=0x20 → one write to address 0 with data 0xA3, `wbm_we_o`=1, and a single `tx_ready_o` pulse.
- **Priority.** LSR=0x21 with a tx byte pending and the rx buffer empty → RBR read first, then LSR re-poll, then the THR write.
- **Timeout.** `ACK_TIMEOUT`=8 and the slave never acks → cyc drops after 8 waiting cycles and `err_o`=1 (sticky). `err_clr_i` clears it. `wbm_err_i` gives the same result.
- **Reset mid-cycle.** Assert `wb_rst_i` during an RBR read → all outputs 0 in the next cycle; after release, the first poll happens `POLL_INTERVAL` cycles later if `int_i`=0.
